queen_solution_checker: RTL and testbench

- Sits directly downstream of the stacked eight-queen solver. It consumes the solver's done / no_answer / out_bus result stream.
- Captures the 8 row masks of a reported placement and independently verifies the board with a sequential pairwise check.
- Replays a verified board as 8 encoded bytes over a valid/ready stream to the display/host side, and reports pass/fail/no-solution status.

---
 rtl/queen_solution_checker.sv | 198 +++++++++++++++++++
 tb/tb_queen_solution_checker.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queen_solution_checker.sv
// Eight-queen solution checker. Captures the solver's row masks, verifies
// the board one queen pair per cycle, then replays a legal board as encoded
// bytes over a valid/ready stream while holding sticky status flags.
module queen_solution_checker #(
  parameter int unsigned N     = 8,
  parameter int unsigned COL_W = 3
) (
  input  logic         clk,
  input  logic         user_reset,
  input  logic         done,
  input  logic         no_answer,
  input  logic [N-1:0] in_bus,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         pass,
  output logic         fail,
  output logic         no_solution,
  output logic         overrun,
  output logic [1:0]   err_code
);

  typedef enum logic [1:0] {StIdle, StCapture, StCheck, StReport} state_e;

  localparam logic [COL_W-1:0] LastIdx      = COL_W'(N - 1);
  localparam logic [COL_W-1:0] LastPairI    = COL_W'(N - 2);
  localparam logic [1:0]       ErrMalformed = 2'd1;
  localparam logic [1:0]       ErrColumn    = 2'd2;
  localparam logic [1:0]       ErrDiagonal  = 2'd3;

  state_e           r_state;
  logic [COL_W-1:0] r_cols [N];
  logic [COL_W-1:0] r_count;     // index of the next row to store
  logic             r_malformed;
  logic [COL_W-1:0] r_pi;
  logic [COL_W-1:0] r_pj;
  logic [COL_W-1:0] r_beat;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_pass;
  logic             r_fail;
  logic             r_no_solution;
  logic             r_overrun;
  logic [1:0]       r_err_code;

  logic [COL_W-1:0] w_col;
  logic             w_onehot;
  logic             w_capture_malformed;
  logic [COL_W-1:0] w_ci;
  logic [COL_W-1:0] w_cj;
  logic [COL_W-1:0] w_dcol;
  logic [COL_W-1:0] w_drow;
  logic             w_col_clash;
  logic             w_diag_clash;
  logic             w_last_pair;
  logic [COL_W-1:0] w_beat_nx;

  // Encode the incoming row mask: lowest set bit wins, one-hot flagged separately
  always_comb begin
    w_col = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (in_bus[k]) begin
        w_col = COL_W'(k);
      end
    end
  end

  assign w_onehot            = $onehot(in_bus);
  assign w_capture_malformed = r_malformed | ~w_onehot;

  // Pairwise attack test for the pair (r_pi, r_pj), r_pi < r_pj always
  assign w_ci         = r_cols[r_pi];
  assign w_cj         = r_cols[r_pj];
  assign w_dcol       = (w_ci >= w_cj) ? (w_ci - w_cj) : (w_cj - w_ci);
  assign w_drow       = r_pj - r_pi;
  assign w_col_clash  = (w_ci == w_cj);
  assign w_diag_clash = (w_dcol == w_drow);
  assign w_last_pair  = (r_pi == LastPairI) && (r_pj == LastIdx);
  assign w_beat_nx    = r_beat + COL_W'(1);

  // Replay byte: last flag, row, spare zero bit, column
  function automatic logic [7:0] beat_word(input logic [COL_W-1:0] row,
                                           input logic [COL_W-1:0] col);
    return {(row == LastIdx), row, 1'b0, col};
  endfunction

  // Control FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!user_reset) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_malformed   <= 1'b0;
      r_pi          <= '0;
      r_pj          <= '0;
      r_beat        <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_no_solution <= 1'b0;
      r_overrun     <= 1'b0;
      r_err_code    <= '0;
      for (int k = 0; k < int'(N); k++) begin
        r_cols[k] <= '0;
      end
    end else begin
      // no_answer is recorded in every state without disturbing the operation
      if (no_answer) begin
        r_no_solution <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (done) begin
            r_cols[0]     <= w_col;
            r_count       <= COL_W'(1);
            r_malformed   <= ~w_onehot;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_err_code    <= '0;
            r_no_solution <= no_answer;
            r_state       <= StCapture;
          end
        end
        StCapture: begin
          if (done) begin
            r_cols[r_count] <= w_col;
            r_count         <= r_count + COL_W'(1);
            r_malformed     <= w_capture_malformed;
            if (r_count == LastIdx) begin
              if (w_capture_malformed) begin
                r_fail     <= 1'b1;
                r_err_code <= ErrMalformed;
                r_state    <= StIdle;
              end else begin
                r_pi    <= '0;
                r_pj    <= COL_W'(1);
                r_state <= StCheck;
              end
            end
          end else begin
            // Burst ended early
            r_fail     <= 1'b1;
            r_err_code <= ErrMalformed;
            r_state    <= StIdle;
          end
        end
        StCheck: begin
          if (done) begin
            r_overrun <= 1'b1;
          end
          if (w_col_clash || w_diag_clash) begin
            r_fail     <= 1'b1;
            r_err_code <= w_col_clash ? ErrColumn : ErrDiagonal;
            r_state    <= StIdle;
          end else if (w_last_pair) begin
            r_pass      <= 1'b1;
            r_beat      <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= beat_word('0, r_cols[0]);
            r_state     <= StReport;
          end else if (r_pj == LastIdx) begin
            r_pi <= r_pi + COL_W'(1);
            r_pj <= r_pi + COL_W'(2);
          end else begin
            r_pj <= r_pj + COL_W'(1);
          end
        end
        StReport: begin
          if (done) begin
            r_overrun <= 1'b1;
          end
          if (out_ready) begin
            if (r_beat == LastIdx) begin
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_state     <= StIdle;
            end else begin
              r_beat     <= w_beat_nx;
              r_out_data <= beat_word(w_beat_nx, r_cols[w_beat_nx]);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy        = (r_state != StIdle);
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign no_solution = r_no_solution;
  assign overrun     = r_overrun;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_queen_solution_checker.sv
// Bench for queen_solution_checker: lockstep stimulus with expectations from a
// board-level model of the checking rules, compared every cycle on negedge.
module tb_queen_solution_checker;

  typedef logic [7:0] board_t [8];

  logic       clk;
  logic       user_reset;
  logic       done;
  logic       no_answer;
  logic [7:0] in_bus;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       pass;
  logic       fail;
  logic       no_solution;
  logic       overrun;
  logic [1:0] err_code;

  queen_solution_checker #(
    .N    (8),
    .COL_W(3)
  ) dut (
    .clk        (clk),
    .user_reset (user_reset),
    .done       (done),
    .no_answer  (no_answer),
    .in_bus     (in_bus),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .no_solution(no_solution),
    .overrun    (overrun),
    .err_code   (err_code)
  );

  // Expected outputs after the most recent edge
  logic       e_busy, e_pass, e_fail, e_nosol, e_overrun, e_valid;
  logic [1:0] e_err;
  logic [7:0] e_data;
  bit         chk_en;

  int         n_checks;
  int         n_err;
  board_t     bd;
  logic [7:0] got [$];
  logic [7:0] lit [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the expectation
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("pass", {31'd0, pass}, {31'd0, e_pass});
      chk("fail", {31'd0, fail}, {31'd0, e_fail});
      chk("no_solution", {31'd0, no_solution}, {31'd0, e_nosol});
      chk("overrun", {31'd0, overrun}, {31'd0, e_overrun});
      chk("err_code", {30'd0, err_code}, {30'd0, e_err});
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
      if (e_valid) chk("out_data", {24'd0, out_data}, {24'd0, e_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    e_busy = 0; e_pass = 0; e_fail = 0; e_nosol = 0;
    e_overrun = 0; e_valid = 0; e_err = 0; e_data = 0;
  endtask

  task automatic do_reset();
    user_reset = 1'b0;
    done       = 1'b0;
    no_answer  = 1'b0;
    tick();
    clear_exp();
    chk("out_data_after_reset", {24'd0, out_data}, 32'd0);
    user_reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic int mask_col(input logic [7:0] m);
    int c = 0;
    for (int k = 7; k >= 0; k--) if (m[k]) c = k;
    return c;
  endfunction

  // kind: 0 legal, 1 malformed, 2 column clash, 3 diagonal clash.
  // ncyc: cycles spent checking pairs until the verdict.
  function automatic void model(output int kind, output int ncyc);
    int col [8];
    int k;
    int d;
    kind = 0;
    ncyc = 28;
    for (int r = 0; r < 8; r++) begin
      if ($countones(bd[r]) != 1) begin
        kind = 1;
        ncyc = 0;
        return;
      end
      col[r] = mask_col(bd[r]);
    end
    k = 0;
    for (int i = 0; i < 7; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        k++;
        d = col[i] - col[j];
        if (d < 0) d = -d;
        if (kind == 0) begin
          if (d == 0) begin
            kind = 2; ncyc = k;
          end else if (d == j - i) begin
            kind = 3; ncyc = k;
          end
        end
      end
    end
  endfunction

  function automatic logic [7:0] beat_byte(input int b);
    return 8'(((b == 7) ? 128 : 0) + b * 16 + mask_col(bd[b]));
  endfunction

  task automatic set_bd(input logic [63:0] v);
    for (int r = 0; r < 8; r++) bd[r] = v[63 - 8 * r -: 8];
  endtask

  // Drive one solver burst and track expectations cycle by cycle.
  task automatic run_board(input int nbeats, input int ready_mode, input bit ovr_check,
                           input bit ovr_rep, input bit noans, input bit noans_start,
                           input int abort_at);
    int kind;
    int ncyc;
    int b;
    int cyc;
    model(kind, ncyc);
    got.delete();
    done      = 1'b1;
    in_bus    = bd[0];
    no_answer = noans_start;
    tick();
    no_answer = 1'b0;
    e_busy = 1; e_pass = 0; e_fail = 0; e_err = 0; e_nosol = noans_start;
    for (int r = 1; r < nbeats; r++) begin
      in_bus = bd[r];
      tick();
      if (r == 7 && kind == 1) begin
        e_busy = 0; e_fail = 1; e_err = 1;
      end
    end
    in_bus = 8'($urandom);
    if (nbeats < 8) begin
      done = 1'b0;
      tick();
      e_busy = 0; e_fail = 1; e_err = 1;
      return;
    end
    if (kind == 1) begin
      done = 1'b0;
      return;
    end
    done = ovr_check;
    for (int c = 1; c <= ncyc; c++) begin
      if (noans && c == 1) no_answer = 1'b1;
      tick();
      if (done) e_overrun = 1;
      if (no_answer) e_nosol = 1;
      done = 1'b0;
      no_answer = 1'b0;
      if (c == ncyc) begin
        if (kind != 0) begin
          e_busy = 0; e_fail = 1; e_err = 2'(kind);
        end else begin
          e_pass = 1; e_valid = 1; e_data = beat_byte(0);
        end
      end
    end
    if (kind != 0) return;
    b = 0;
    cyc = 0;
    while (b < 8) begin
      cyc++;
      unique case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc - 1) % 3 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1) || (cyc % 4 == 0);
      endcase
      if (abort_at != 0 && cyc == abort_at) begin
        do_reset();
        out_ready = 1'b0;
        return;
      end
      if (ovr_rep && cyc == 2) done = 1'b1;
      if (noans && cyc == 3) no_answer = 1'b1;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      if (done) e_overrun = 1;
      if (no_answer) e_nosol = 1;
      done = 1'b0;
      no_answer = 1'b0;
      if (out_ready) b++;
      e_valid = (b < 8);
      e_busy  = (b < 8);
      if (b < 8) e_data = beat_byte(b);
    end
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    done = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_got_literal();
    chk("beat_count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk("beat_byte", {24'd0, got[i]}, {24'd0, lit[i]});
    end
  endtask

  task automatic set_random_board(input int sel);
    int sol [2][8];
    int c [8];
    int w;
    int tmp;
    int v;
    int p;
    sol[0] = '{0, 4, 7, 5, 2, 6, 1, 3};
    sol[1] = '{0, 5, 7, 2, 6, 3, 1, 4};
    if (sel == 0) begin
      w = $urandom_range(0, 1);
      v = $urandom_range(0, 3);
      for (int r = 0; r < 8; r++) begin
        c[r] = sol[w][(v & 2) != 0 ? 7 - r : r];
        if ((v & 1) != 0) c[r] = 7 - c[r];
      end
    end else begin
      for (int r = 0; r < 8; r++) c[r] = r;
      for (int r = 7; r > 0; r--) begin
        p = $urandom_range(0, r);
        tmp = c[r]; c[r] = c[p]; c[p] = tmp;
      end
    end
    for (int r = 0; r < 8; r++) bd[r] = 8'(1 << c[r]);
    if (sel == 2) for (int r = 0; r < 8; r++) bd[r] = 8'(1 << $urandom_range(0, 7));
    if (sel == 3) bd[$urandom_range(0, 7)] = 8'($urandom);
  endtask

  initial begin
    int kind;
    int ncyc;
    int sel;
    n_checks   = 0;
    n_err      = 0;
    chk_en     = 0;
    user_reset = 1'b0;
    done       = 1'b0;
    no_answer  = 1'b0;
    in_bus     = 8'h00;
    out_ready  = 1'b0;
    clear_exp();
    lit = '{8'h00, 8'h14, 8'h27, 8'h35, 8'h42, 8'h56, 8'h61, 8'hF3};
    tick();
    do_reset();
    chk_en = 1;
    idle(2);

    // Pin the model with hand-computed verdicts
    set_bd(64'h01_10_80_20_04_40_02_08);
    model(kind, ncyc);
    chk("model_legal_kind", kind, 0);
    chk("model_legal_cycles", ncyc, 28);
    chk("model_beat7", {24'd0, beat_byte(7)}, 32'hF3);
    set_bd(64'h01_02_04_08_10_20_40_80);
    model(kind, ncyc);
    chk("model_diag_kind", kind, 3);
    chk("model_diag_cycles", ncyc, 1);
    set_bd(64'h01_01_80_20_04_40_02_08);
    model(kind, ncyc);
    chk("model_col_kind", kind, 2);
    set_bd(64'h01_10_80_03_04_40_02_08);
    model(kind, ncyc);
    chk("model_malformed_kind", kind, 1);

    // Legal board, always ready
    set_bd(64'h01_10_80_20_04_40_02_08);
    run_board(8, 0, 0, 0, 0, 0, 0);
    check_got_literal();
    idle(2);
    // Legal board, ready pattern 1,0,0
    run_board(8, 1, 0, 0, 0, 0, 0);
    check_got_literal();
    idle(2);
    // Main diagonal
    set_bd(64'h01_02_04_08_10_20_40_80);
    run_board(8, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Column clash, then malformed row
    set_bd(64'h01_01_80_20_04_40_02_08);
    run_board(8, 0, 0, 0, 0, 0, 0);
    idle(2);
    set_bd(64'h01_10_80_03_04_40_02_08);
    run_board(8, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Short burst, then no_answer in IDLE
    set_bd(64'h01_10_80_20_04_40_02_08);
    run_board(5, 0, 0, 0, 0, 0, 0);
    idle(2);
    no_answer = 1'b1;
    tick();
    no_answer = 1'b0;
    e_nosol = 1;
    idle(3);
    // Overrun during REPORT and CHECK, no_answer in flight, done+no_answer together
    run_board(8, 2, 1, 1, 1, 1, 0);
    check_got_literal();
    idle(2);
    // Reset mid-REPORT
    run_board(8, 1, 0, 0, 0, 0, 4);
    idle(2);

    // Randomized boards
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 4);
      set_random_board(sel == 4 ? 0 : sel);
      run_board(sel == 4 ? $urandom_range(1, 7) : 8, $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0);
      idle($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) begin
        no_answer = 1'b1;
        tick();
        no_answer = 1'b0;
        e_nosol = 1;
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
